prescaled_timer: RTL and testbench

- Parametrised up-counting timer: the successor of the plain enable-counter.
- Adds a programmable prescaler, a compare register and four run modes (free-run wrap, periodic auto-reload, one-shot, saturating).
- Provides synchronous load, start/stop control and a sticky interrupt-pending flag.
- Sits beside the CPU's CSR/MMIO peripherals as the timebase for scheduler ticks and timeouts.

---
 rtl/prescaled_timer.sv | 132 +++++++++++++
 tb/tb_prescaled_timer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prescaled_timer.sv
// prescaled_timer: up-counting timebase with programmable prescaler, compare
// match, four run modes (free-run wrap, periodic reload, one-shot, saturate),
// synchronous load, start/stop control and a sticky interrupt-pending flag.
//
// Control handshake: start, stop, load and irq_clr are single-cycle pulses,
// sampled on every rising clock edge with no valid/ready pairing. Each one is
// acted on at the edge where it is high. Priority order is load (count/pcnt),
// then stop, then start. A load or a stop suppresses tick processing in that
// cycle.
module prescaled_timer #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]          compare,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      irq_clr,
  output logic [WIDTH-1:0]          count,
  output logic                      running,
  output logic                      tick,
  output logic                      match_pulse,
  output logic                      ovf_pulse,
  output logic                      irq_pending,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0]       MODE_FREE     = 2'b00;
  localparam logic [1:0]       MODE_PERIODIC = 2'b01;
  localparam logic [1:0]       MODE_ONESHOT  = 2'b10;
  localparam logic [1:0]       MODE_SAT      = 2'b11;
  localparam logic [WIDTH-1:0] ONES          = '1;

  state_t                    state, state_next;
  logic [PRESCALE_WIDTH-1:0] pcnt, pcnt_next;
  logic [WIDTH-1:0]          count_next;
  logic                      is_match;
  logic                      eff_tick;
  logic                      restart;
  logic                      match_next;
  logic                      ovf_next;
  logic                      irq_next;

  assign running   = (state == S_RUN);
  assign tick      = running && (pcnt == prescale);
  assign is_match  = (count == compare);
  // A tick only advances the counter when neither load nor stop overrides it.
  assign eff_tick  = tick && !load && !stop;
  // Restart from DONE clears count and prescaler before counting again.
  assign restart   = start && !stop && (state == S_DONE);
  assign state_dbg = state;

  // Next-state, next-count and pulse generation.
  always_comb begin
    state_next = state;
    count_next = count;
    pcnt_next  = pcnt;
    match_next = 1'b0;
    ovf_next   = 1'b0;
    irq_next   = irq_pending;

    if (stop) begin
      state_next = S_IDLE;
    end else if (start && state != S_RUN) begin
      state_next = S_RUN;
    end else if (eff_tick && is_match && mode == MODE_ONESHOT) begin
      state_next = S_DONE;
    end

    if (load) begin
      count_next = load_value;
    end else if (restart) begin
      count_next = '0;
    end else if (eff_tick) begin
      case (mode)
        MODE_FREE:     count_next = count + WIDTH'(1);
        MODE_PERIODIC: count_next = is_match ? '0 : count + WIDTH'(1);
        MODE_ONESHOT:  count_next = is_match ? count : count + WIDTH'(1);
        MODE_SAT:      count_next = (count == ONES) ? count : count + WIDTH'(1);
        default:       count_next = count;
      endcase
    end

    // pcnt wraps naturally if prescale is lowered below its current value.
    if (load || stop || restart || tick) begin
      pcnt_next = '0;
    end else if (running) begin
      pcnt_next = pcnt + PRESCALE_WIDTH'(1);
    end

    match_next = eff_tick && is_match;
    ovf_next   = eff_tick && (mode == MODE_FREE) && (count == ONES);

    // A fresh match outranks a clear in the same cycle.
    if (match_next) begin
      irq_next = 1'b1;
    end else if (irq_clr) begin
      irq_next = 1'b0;
    end
  end

  // State, counters and registered pulse outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      count       <= '0;
      pcnt        <= '0;
      match_pulse <= 1'b0;
      ovf_pulse   <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      pcnt        <= pcnt_next;
      match_pulse <= match_next;
      ovf_pulse   <= ovf_next;
      irq_pending <= irq_next;
    end
  end

endmodule

// File: tb/tb_prescaled_timer.sv
// Directed testbench for prescaled_timer (WIDTH=8) with hand-computed
// expected values.
module tb_prescaled_timer;

  localparam int W  = 8;
  localparam int PW = 8;

  // clock / reset
  logic          clk = 1'b0;
  logic          resetn;
  logic          start, stop, load, irq_clr;
  logic [1:0]    mode;
  logic [PW-1:0] prescale;
  logic [W-1:0]  compare, load_value;
  logic [W-1:0]  count;
  logic          running, tick, match_pulse, ovf_pulse, irq_pending;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prescaled_timer #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .mode(mode),
    .prescale(prescale), .compare(compare), .load(load),
    .load_value(load_value), .irq_clr(irq_clr), .count(count),
    .running(running), .tick(tick), .match_pulse(match_pulse),
    .ovf_pulse(ovf_pulse), .irq_pending(irq_pending), .state_dbg(state_dbg)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_value = v; step(); load = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; irq_clr = 1'b0;
    mode = 2'b00; prescale = '0; compare = 8'hAA; load_value = '0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_running", 32'(running), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_match", 32'(match_pulse), 0);
    check("rst_ovf", 32'(ovf_pulse), 0);
    check("rst_irq", 32'(irq_pending), 0);
    step();
    resetn = 1'b1;
    step();

    // async reset in the middle of a run at count 0x55
    do_load(8'h55);
    check("load_55", 32'(count), 32'h55);
    pulse_start();
    check("run_55", 32'(running), 1);
    check("run_hold_55", 32'(count), 32'h55);
    step(); step();
    check("run_57", 32'(count), 32'h57);
    resetn = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_running", 32'(running), 0);
    check("arst_tick", 32'(tick), 0);
    check("arst_irq", 32'(irq_pending), 0);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_no_tick", 32'(tick), 0);
    end
    check("idle_count", 32'(count), 0);

    // periodic: prescale 2, compare 3
    mode = 2'b01; prescale = 8'd2; compare = 8'd3;
    pulse_start();
    for (int i = 1; i <= 12; i++) begin
      step();
      check("per_count", 32'(count), (i == 12) ? 0 : i / 3);
      check("per_tick", 32'(tick), (i % 3 == 2) ? 1 : 0);
      check("per_match", 32'(match_pulse), (i == 12) ? 1 : 0);
      check("per_irq", 32'(irq_pending), (i == 12) ? 1 : 0);
    end
    for (int i = 13; i <= 23; i++) step();
    check("per_pre2_count", 32'(count), 3);
    check("per_pre2_match", 32'(match_pulse), 0);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("per_m2_match", 32'(match_pulse), 1);
    check("per_m2_irq_kept", 32'(irq_pending), 1);
    check("per_m2_count", 32'(count), 0);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("per_irq_clr", 32'(irq_pending), 0);
    check("per_match_fall", 32'(match_pulse), 0);
    pulse_stop();
    check("per_stop", 32'(running), 0);

    // one-shot: prescale 0, compare 5
    mode = 2'b10; prescale = '0; compare = 8'd5;
    do_load(8'd0);
    pulse_start();
    for (int k = 1; k <= 5; k++) begin
      step();
      check("os_count", 32'(count), k);
      check("os_match_lo", 32'(match_pulse), 0);
    end
    step();
    check("os_match", 32'(match_pulse), 1);
    check("os_running", 32'(running), 0);
    check("os_state_done", 32'(state_dbg), 2);
    check("os_count_hold", 32'(count), 5);
    check("os_irq", 32'(irq_pending), 1);
    step(); step();
    check("os_single_pulse", 32'(match_pulse), 0);
    check("os_still_5", 32'(count), 5);
    pulse_start();
    check("os_restart_count", 32'(count), 0);
    check("os_restart_run", 32'(running), 1);
    step();
    check("os_restart_inc", 32'(count), 1);
    pulse_stop();
    irq_clr = 1'b1; step(); irq_clr = 1'b0;

    // free-run wrap
    mode = 2'b00; prescale = '0; compare = 8'h10;
    do_load(8'hFE);
    pulse_start();
    check("free_fe", 32'(count), 32'hFE);
    step();
    check("free_ff", 32'(count), 32'hFF);
    check("free_no_ovf", 32'(ovf_pulse), 0);
    step();
    check("free_00", 32'(count), 0);
    check("free_ovf", 32'(ovf_pulse), 1);
    check("free_no_match", 32'(match_pulse), 0);
    step();
    check("free_01", 32'(count), 1);
    check("free_ovf_fall", 32'(ovf_pulse), 0);
    pulse_stop();

    // saturate
    mode = 2'b11; compare = 8'hFF;
    do_load(8'hFD);
    pulse_start();
    step();
    check("sat_fe", 32'(count), 32'hFE);
    check("sat_fe_match", 32'(match_pulse), 0);
    step();
    check("sat_ff", 32'(count), 32'hFF);
    check("sat_ff_match", 32'(match_pulse), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sat_hold", 32'(count), 32'hFF);
      check("sat_match_each", 32'(match_pulse), 1);
      check("sat_no_ovf", 32'(ovf_pulse), 0);
    end
    pulse_stop();

    // load colliding with a matching tick
    mode = 2'b00; compare = 8'd3;
    do_load(8'd2);
    pulse_start();
    step();
    check("col_pre", 32'(count), 3);
    check("col_tick", 32'(tick), 1);
    load = 1'b1; load_value = 8'd7;
    step();
    load = 1'b0;
    check("col_count", 32'(count), 7);
    check("col_no_match", 32'(match_pulse), 0);
    step();
    check("col_next", 32'(count), 8);
    check("col_no_match2", 32'(match_pulse), 0);
    pulse_stop();

    // start and stop together from IDLE
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_running", 32'(running), 0);
    check("ss_state", 32'(state_dbg), 0);
    step();
    check("ss_count", 32'(count), 8);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
